// File: rtl/dm_access_unit_pkg.sv
// dm_access_unit_pkg: op and state encodings plus store lane helpers for the data-memory access unit.
package dm_access_unit_pkg;
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;

    typedef enum logic [1:0] {S_IDLE, S_STORE, S_LOAD_WAIT, S_DONE} state_e;

    function automatic logic is_store(input logic [2:0] op);
        return op >= OP_SW;
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        return (op == OP_LW || op == OP_SW) ? (a != 2'd0) :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? a[0] : 1'b0;
    endfunction

    function automatic logic [3:0] store_byteen(input logic [2:0] op, input logic [1:0] a);
        return op == OP_SW ? BE_WORD : op == OP_SH ? (a[1] ? BE_HI : BE_LO) : 4'b0001 << a;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] op, input logic [31:0] w);
        return op == OP_SW ? w : op == OP_SH ? {2{w[15:0]}} : {4{w[7:0]}};
    endfunction
endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: selects the addressed byte/half of a memory word and sign- or zero-extends it.
module dm_load_ext
    import dm_access_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    assign b = rdata[{addr, 3'b000} +: 8];
    assign h = addr[1] ? rdata[31:16] : rdata[15:0];
    assign data = op == OP_LB  ? {{24{b[7]}}, b} :
                  op == OP_LBU ? {24'd0, b} :
                  op == OP_LH  ? {{16{h[15]}}, h} :
                  op == OP_LHU ? {16'd0, h} : rdata;
endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: single-request load/store initiator for the data-memory port with error suppression.
module dm_access_unit
    import dm_access_unit_pkg::*;
#(
    parameter int          LOAD_LAT   = 1,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    input  logic [4:0]  req_rd,
    output logic [31:0] m_data_addr,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_inst_addr,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_we,
    output logic [31:0] resp_pc,
    output logic        resp_err
);
    state_e      state;
    logic [2:0]  op_q;
    logic [31:0] addr_q, wdata_q, pc_q, rdata_q, ext;
    logic [4:0]  rd_q;
    logic        err_q, req_err;
    logic [1:0]  cnt;

    assign req_err = misaligned(req_op, req_addr[1:0]) || req_addr >= ADDR_LIMIT;

    dm_load_ext u_ext (.op(op_q), .addr(addr_q[1:0]), .rdata(m_data_rdata), .data(ext));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            pc_q    <= 32'd0;
            rd_q    <= 5'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    op_q    <= req_op;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    pc_q    <= req_pc;
                    rd_q    <= req_rd;
                    err_q   <= req_err;
                    rdata_q <= 32'd0;
                    cnt     <= 2'(LOAD_LAT - 1);
                    state   <= req_err ? S_DONE : is_store(req_op) ? S_STORE : S_LOAD_WAIT;
                end
                S_STORE: state <= S_DONE;
                S_LOAD_WAIT: if (cnt == 2'd0) begin
                    rdata_q <= ext;
                    state   <= S_DONE;
                end else begin
                    cnt <= cnt - 2'd1;
                end
                S_DONE: state <= S_IDLE;
            endcase
        end
    end

    // Errors never reach S_STORE, so byteen needs no separate error gate.
    assign req_ready     = state == S_IDLE;
    assign m_data_addr   = addr_q;
    assign m_inst_addr   = pc_q;
    assign m_data_wdata  = store_lanes(op_q, wdata_q);
    assign m_data_byteen = state == S_STORE ? store_byteen(op_q, addr_q[1:0]) : 4'd0;
    assign resp_valid    = state == S_DONE;
    assign resp_we       = resp_valid && !is_store(op_q) && !err_q && rd_q != 5'd0;
    assign resp_rdata    = rdata_q;
    assign resp_rd       = rd_q;
    assign resp_pc       = pc_q;
    assign resp_err      = err_q;
endmodule

// File: tb/tb_dm_access_unit.sv
// tb_dm_access_unit: drives LOAD_LAT=1 and LOAD_LAT=3 units in lockstep against a byte-level memory model.
module tb_dm_access_unit;
    logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, req_pc = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic        ready [2], rv [2], rwe [2], rerr [2];
    logic [31:0] maddr [2], mrdata [2], mwdata [2], miaddr [2], rdat [2], rpc [2];
    logic [3:0]  mbe [2];
    logic [4:0]  rrd [2];
    logic [31:0] mem [2][4096];
    logic [7:0]  rb [12288];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dm_access_unit #(.LOAD_LAT(g == 0 ? 1 : 3)) u (
            .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready[g]),
            .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
            .req_rd(req_rd), .m_data_addr(maddr[g]), .m_data_rdata(mrdata[g]),
            .m_data_wdata(mwdata[g]), .m_data_byteen(mbe[g]), .m_inst_addr(miaddr[g]),
            .resp_valid(rv[g]), .resp_rdata(rdat[g]), .resp_rd(rrd[g]), .resp_we(rwe[g]),
            .resp_pc(rpc[g]), .resp_err(rerr[g]));
        assign mrdata[g] = mem[g][maddr[g][13:2]];
    end

    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++)
                if (mbe[d][i]) mem[d][maddr[d][13:2]][8*i +: 8] <= mwdata[d][8*i +: 8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] op);
        return (op == 3'd0 || op == 3'd5) ? 4 : (op == 3'd1 || op == 3'd2 || op == 3'd6) ? 2 : 1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] v = 32'd0;
        int n = op_size(op);
        for (int k = 0; k < n; k++) v = v | (32'(rb[a + k]) << (8 * k));
        if (op == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        if (op == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
        return v;
    endfunction

    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] pc, input logic [4:0] rd);
        int n = op_size(op);
        bit st = op >= 3'd5;
        bit err = a >= 32'h3000 || (a % n) != 0;
        logic [3:0] be = 4'd0;
        logic [31:0] lanes = n == 4 ? w : n == 2 ? {w[15:0], w[15:0]} : {4{w[7:0]}};
        logic [31:0] exp_rd = (!st && !err) ? ref_load(op, a) : 32'd0;
        int lat [2];
        int seen [2];
        int pulses [2];
        for (int k = 0; k < n; k++) be[(a % 4) + k] = 1'b1;
        lat[0] = err ? 1 : st ? 2 : 2;
        lat[1] = err ? 1 : st ? 2 : 4;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check("ready_idle", 32'(ready[d]), 32'd1);
        req_op = op; req_addr = a; req_wdata = w; req_pc = pc; req_rd = rd; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom; req_pc = $urandom;
        req_rd = 5'($urandom);
        pulses[0] = 0; pulses[1] = 0; seen[0] = 0; seen[1] = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("byteen", 32'(mbe[d]), (st && !err && c == 1) ? 32'(be) : 32'd0);
                check("ready", 32'(ready[d]), 32'(c > lat[d]));
                check("m_data_addr", maddr[d], a);
                check("m_inst_addr", miaddr[d], pc);
                if (st && c == 1) check("wdata", mwdata[d], lanes);
                if (rv[d]) begin
                    pulses[d]++; seen[d] = c;
                    check("resp_rdata", rdat[d], exp_rd);
                    check("resp_we", 32'(rwe[d]), 32'(!st && !err && rd != 5'd0));
                    check("resp_err", 32'(rerr[d]), 32'(err));
                    check("resp_rd", 32'(rrd[d]), 32'(rd));
                    check("resp_pc", rpc[d], pc);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            check("pulses", pulses[d], 1);
            check("latency", seen[d], lat[d]);
        end
        if (st && !err) for (int k = 0; k < n; k++) rb[a + k] = w[8*k +: 8];
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 12288; i++) rb[i] = 8'd0;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 4096; i++) mem[d][i] = 32'd0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(ready[d]), 32'd1);
            check("rst_valid", 32'(rv[d]), 32'd0);
            check("rst_byteen", 32'(mbe[d]), 32'd0);
            check("rst_we", 32'(rwe[d]), 32'd0);
            check("rst_rdata", rdat[d], 32'd0);
            check("rst_addr", maddr[d], 32'd0);
        end
        reset = 1'b1;
        do_req(3'd5, 32'h10, 32'h12345678, 32'h3000, 5'd0);
        do_req(3'd7, 32'h13, 32'h000000AB, 32'h3004, 5'd0);
        do_req(3'd4, 32'h13, 32'h0, 32'h3008, 5'd8);
        do_req(3'd3, 32'h13, 32'h0, 32'h300C, 5'd9);
        do_req(3'd6, 32'h16, 32'h00008001, 32'h3010, 5'd0);
        do_req(3'd1, 32'h16, 32'h0, 32'h3014, 5'd3);
        do_req(3'd2, 32'h16, 32'h0, 32'h3018, 5'd4);
        do_req(3'd0, 32'h6, 32'h0, 32'h301C, 5'd5);
        do_req(3'd6, 32'h5, 32'hFFFF, 32'h3020, 5'd0);
        do_req(3'd0, 32'h3000, 32'h0, 32'h3024, 5'd6);
        do_req(3'd5, 32'h3000, 32'hDEADBEEF, 32'h3028, 5'd0);
        do_req(3'd0, 32'h10, 32'h0, 32'h302C, 5'd0);
        do_req(3'd0, 32'h10, 32'h0, 32'h3030, 5'd7);
        do_req(3'd5, 32'h2FFC, 32'hCAFEF00D, 32'h3034, 5'd0);
        do_req(3'd0, 32'h2FFC, 32'h0, 32'h3038, 5'd1);
        for (int t = 0; t < 60; t++) begin
            int kind = $urandom_range(0, 9);
            logic [31:0] a = kind == 0 ? 32'h3000 + $urandom_range(0, 15) :
                             kind == 1 ? 32'h2FF0 + $urandom_range(0, 15) : 32'($urandom_range(0, 63));
            do_req(3'($urandom), a, $urandom, $urandom, 5'($urandom));
        end
        @(negedge clk);
        req_op = 3'd5; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_pc = 32'h4000; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 reset = 1'b0;
        #1 for (int d = 0; d < 2; d++) check("midrst_byteen", 32'(mbe[d]), 32'd0);
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("midrst_byteen", 32'(mbe[d]), 32'd0);
                check("midrst_valid", 32'(rv[d]), 32'd0);
            end
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("post_rst_ready", 32'(ready[d]), 32'd1);
                check("post_rst_valid", 32'(rv[d]), 32'd0);
            end
        end
        do_req(3'd0, 32'h20, 32'h0, 32'h4004, 5'd2);
        for (int d = 0; d < 2; d++) begin
            bad = 0;
            for (int i = 0; i < 3072; i++)
                if (mem[d][i] !== {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]}) bad++;
            check("memory_words_wrong", bad, 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
